// File: rtl/dcache_tile_port.sv
// Initiator port for the banked dcache: one SZ-row tile load/store per request.
// The tile goes out as one strided access, or as SZ single-row accesses when the row banks collide.
module dcache_tile_port #(
  parameter int SZ      = 4,
  parameter int LOGCNT  = 5,
  parameter int BITS    = 18,
  parameter int ACC_CYC = 5
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [10+LOGCNT-1:0]        req_addr,
  input  logic [10+LOGCNT-2:0]        req_stride,
  input  logic [BITS*SZ*SZ-1:0]       req_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [BITS*SZ*SZ-1:0]       resp_data,
  output logic [2:0]                  resp_passes,
  output logic [10+LOGCNT-1:0]        dc_addr,
  output logic [10+LOGCNT-2:0]        dc_stride_x,
  output logic [10+LOGCNT-2:0]        dc_stride_y,
  output logic [BITS*SZ*SZ-1:0]       dc_dat_w,
  output logic                        dc_we,
  input  logic [BITS*SZ*SZ-1:0]       dc_dat_r
);

  localparam int AW  = 10 + LOGCNT;
  localparam int SW  = AW - 1;
  localparam int RW  = BITS * SZ;
  localparam int CW  = $clog2(ACC_CYC);
  localparam int RCW = (SZ > 1) ? $clog2(SZ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]           state_reg;
  logic                 we_reg;
  logic [AW-1:0]        addr_reg;
  logic [SW-1:0]        stride_reg;
  logic [SZ*RW-1:0]     data_reg;
  logic [RW-1:0]        cap_reg [SZ];
  logic                 conflict_reg;
  logic [RCW-1:0]       row_reg;
  logic [CW-1:0]        cyc_reg;

  logic [AW-1:0]        row_addr [SZ];
  logic [RW-1:0]        data_row [SZ];
  logic [SZ*SZ-1:0]     pair_hit;
  logic                 conflict;

  // Row addresses wrap silently modulo 2^AW; only the low LOGCNT bits pick the bank.
  for (genvar gi = 0; gi < SZ; gi++) begin : g_row
    assign row_addr[gi] = addr_reg + AW'(stride_reg) * AW'(gi);
    assign data_row[gi] = data_reg[RW*gi +: RW];
    assign resp_data[RW*gi +: RW] = (state_reg == S_RESP) ? cap_reg[gi] : '0;
    for (genvar gj = 0; gj < SZ; gj++) begin : g_pair
      if (gj > gi) begin : g_cmp
        assign pair_hit[gi*SZ+gj] = (row_addr[gi][LOGCNT-1:0] == row_addr[gj][LOGCNT-1:0]);
      end else begin : g_none
        assign pair_hit[gi*SZ+gj] = 1'b0;
      end
    end
  end

  assign conflict    = |pair_hit;
  assign req_ready   = (state_reg == S_IDLE);
  assign resp_valid  = (state_reg == S_RESP);
  assign resp_passes = (state_reg != S_RESP) ? 3'd0 : (conflict_reg ? 3'(SZ) : 3'd1);
  assign dc_stride_x = '0;

  // dcache inputs are decoded from registered state, so they hold steady for the whole access.
  always_comb begin
    dc_addr     = '0;
    dc_stride_y = '0;
    dc_dat_w    = '0;
    dc_we       = 1'b0;
    if (state_reg == S_ACCESS) begin
      dc_we = we_reg;
      if (conflict_reg) begin
        dc_addr          = row_addr[row_reg];
        dc_dat_w[RW-1:0] = data_row[row_reg];
      end else begin
        dc_addr     = addr_reg;
        dc_stride_y = stride_reg;
        dc_dat_w    = data_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      stride_reg   <= '0;
      data_reg     <= '0;
      conflict_reg <= 1'b0;
      row_reg      <= '0;
      cyc_reg      <= '0;
      for (int i = 0; i < SZ; i++) cap_reg[i] <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            addr_reg   <= req_addr;
            stride_reg <= req_stride;
            data_reg   <= req_data;
            for (int i = 0; i < SZ; i++) cap_reg[i] <= '0;
            state_reg  <= S_CHECK;
          end
        end
        S_CHECK: begin
          conflict_reg <= conflict;
          row_reg      <= '0;
          cyc_reg      <= '0;
          state_reg    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cyc_reg == CW'(ACC_CYC - 1)) begin
            // dat_r is sampled on the last held cycle, when the dcache result is settled.
            if (!we_reg) begin
              if (conflict_reg) begin
                cap_reg[row_reg] <= dc_dat_r[RW-1:0];
              end else begin
                for (int i = 0; i < SZ; i++) cap_reg[i] <= dc_dat_r[RW*i +: RW];
              end
            end
            cyc_reg   <= '0;
            state_reg <= S_GAP;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        S_GAP: begin
          if (conflict_reg && (row_reg != RCW'(SZ - 1))) begin
            row_reg   <= row_reg + 1'b1;
            state_reg <= S_ACCESS;
          end else begin
            state_reg <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tile_port.sv
// Self-checking bench for dcache_tile_port: a simple row-addressed dcache model plus a
// transaction-level reference memory that predicts pass count, latency and load data.
module tb_dcache_tile_port;

  localparam int SZ      = 4;
  localparam int LOGCNT  = 5;
  localparam int BITS    = 18;
  localparam int ACC_CYC = 5;
  localparam int AW      = 10 + LOGCNT;
  localparam int SW      = AW - 1;
  localparam int RW      = BITS * SZ;
  localparam int TW      = RW * SZ;
  localparam int DEPTH   = 1 << AW;

  logic          clk;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_stride;
  logic [TW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [TW-1:0] resp_data;
  logic [2:0]    resp_passes;
  logic [AW-1:0] dc_addr;
  logic [SW-1:0] dc_stride_x;
  logic [SW-1:0] dc_stride_y;
  logic [TW-1:0] dc_dat_w;
  logic          dc_we;
  logic [TW-1:0] dc_dat_r;

  dcache_tile_port #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS), .ACC_CYC(ACC_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_stride(req_stride), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_passes(resp_passes),
    .dc_addr(dc_addr), .dc_stride_x(dc_stride_x), .dc_stride_y(dc_stride_y),
    .dc_dat_w(dc_dat_w), .dc_we(dc_we), .dc_dat_r(dc_dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dcache model: one RW-bit row per address; with colliding row addresses the lowest row wins.
  logic [RW-1:0] dmem [0:DEPTH-1];
  always @(posedge clk) begin
    if (dc_we) begin
      for (int y = SZ - 1; y >= 0; y--) dmem[AW'(dc_addr + dc_stride_y * y)] <= dc_dat_w[RW*y +: RW];
    end
  end
  always @(negedge clk) begin
    for (int y = 0; y < SZ; y++) dc_dat_r[RW*y +: RW] <= dmem[AW'(dc_addr + dc_stride_y * y)];
  end

  // Reference: memory as seen by whole-tile transactions.
  logic [RW-1:0] ref_mem [0:DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int row_a(input logic [AW-1:0] a, input logic [SW-1:0] s, input int y);
    return (int'(a) + int'(s) * y) % DEPTH;
  endfunction

  function automatic bit ref_conflict(input logic [AW-1:0] a, input logic [SW-1:0] s);
    for (int y = 0; y < SZ; y++)
      for (int z = y + 1; z < SZ; z++)
        if ((row_a(a, s, y) % (1 << LOGCNT)) == (row_a(a, s, z) % (1 << LOGCNT))) return 1'b1;
    return 1'b0;
  endfunction

  // Applies a transaction to the reference memory and returns the expected load data.
  function automatic logic [TW-1:0] ref_apply(input logic we, input logic [AW-1:0] a,
                                              input logic [SW-1:0] s, input logic [TW-1:0] d);
    logic [TW-1:0] r;
    r = '0;
    for (int y = 0; y < SZ; y++) begin
      if (we) ref_mem[row_a(a, s, y)] = d[RW*y +: RW];
      else    r[RW*y +: RW] = ref_mem[row_a(a, s, y)];
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] make_tile(input int seed);
    logic [TW-1:0] t;
    for (int y = 0; y < SZ; y++)
      for (int x = 0; x < SZ; x++)
        t[BITS*(SZ*y+x) +: BITS] = BITS'((y + 1) * 'h11111 + seed * 'h0101 + x * 'h10);
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int e = 0; e < SZ * SZ; e++) t[BITS*e +: BITS] = BITS'($urandom);
    return t;
  endfunction

  // Called at a falling edge with the port idle; returns at a falling edge after the response.
  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [TW-1:0] d, output logic [TW-1:0] rd, output int rp,
                         output int lat, output int we_cyc, output int we_pls,
                         output int snz, output int sxnz);
    int   guard;
    logic prev;
    req_we = we; req_addr = a; req_stride = s; req_data = d; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; we_cyc = 0; we_pls = 0; snz = 0; sxnz = 0; prev = 1'b0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      if (dc_we === 1'b1) begin
        we_cyc++;
        if (!prev) we_pls++;
      end
      prev = dc_we;
      if (dc_stride_y != '0) snz++;
      if (dc_stride_x != '0) sxnz++;
      @(negedge clk);
      lat++;
    end
    rd = resp_data;
    rp = int'(resp_passes);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [SW-1:0] s, input logic [TW-1:0] d,
                        input int exp_p, input int exp_l);
    logic [TW-1:0] exp_d, rd;
    int rp, lat, we_cyc, we_pls, snz, sxnz;
    exp_d = ref_apply(we, a, s, d);
    run_req(we, a, s, d, rd, rp, lat, we_cyc, we_pls, snz, sxnz);
    $display("txn %s we=%0d addr=%h stride=%h passes=%0d latency=%0d", tag, we, a, s, rp, lat);
    check_int({tag, " passes"}, rp, exp_p);
    check_int({tag, " latency"}, lat, exp_l);
    check({tag, " data"}, rd, exp_d);
    check_int({tag, " we cycles"}, we_cyc, we ? ACC_CYC * exp_p : 0);
    check_int({tag, " we pulses"}, we_pls, we ? exp_p : 0);
    check_int({tag, " stride_x"}, sxnz, 0);
    if (exp_p == SZ) check_int({tag, " slow stride_y"}, snz, 0);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [SW-1:0] stride;
    int            seed;
    int            exp_passes;
    int            exp_lat;
  } vec_t;

  vec_t vecs [12];

  localparam int LAT_FAST = 2 + ACC_CYC + 1;
  localparam int LAT_SLOW = 2 + SZ * (ACC_CYC + 1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] exp_a, exp_b, snap;
    logic [TW-1:0] rd;
    int            guard, seen;
    logic          we;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [TW-1:0] d;
    bit            conf;
    logic [SW-1:0] strides [8];

    vecs[0]  = '{1'b1, 15'h0000, 14'd1,  1, 1,  LAT_FAST};
    vecs[1]  = '{1'b0, 15'h0000, 14'd1,  0, 1,  LAT_FAST};
    vecs[2]  = '{1'b1, 15'h0000, 14'd32, 2, SZ, LAT_SLOW};
    vecs[3]  = '{1'b0, 15'h0000, 14'd32, 0, SZ, LAT_SLOW};
    vecs[4]  = '{1'b1, 15'h0005, 14'd16, 3, SZ, LAT_SLOW};
    vecs[5]  = '{1'b0, 15'h0005, 14'd0,  0, SZ, LAT_SLOW};
    vecs[6]  = '{1'b0, 15'h0015, 14'd0,  0, SZ, LAT_SLOW};
    vecs[7]  = '{1'b0, 15'h0025, 14'd0,  0, SZ, LAT_SLOW};
    vecs[8]  = '{1'b0, 15'h0035, 14'd0,  0, SZ, LAT_SLOW};
    vecs[9]  = '{1'b1, 15'h7FFF, 14'd1,  4, 1,  LAT_FAST};
    vecs[10] = '{1'b0, 15'h7FFF, 14'd1,  0, 1,  LAT_FAST};
    vecs[11] = '{1'b0, 15'h0000, 14'd0,  0, SZ, LAT_SLOW};

    for (int i = 0; i < DEPTH; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end

    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_stride = '0;
    req_data = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset req_ready", int'(req_ready), 1);
    check_int("reset resp_valid", int'(resp_valid), 0);
    check("reset resp_data", resp_data, '0);
    check_int("reset resp_passes", int'(resp_passes), 0);
    check_int("reset dc_we", int'(dc_we), 0);
    check_int("reset dc_addr", int'(dc_addr), 0);
    check_int("reset dc_stride_y", int'(dc_stride_y), 0);
    check("reset dc_dat_w", dc_dat_w, '0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].stride,
             vecs[i].we ? make_tile(vecs[i].seed) : make_tile(99),
             vecs[i].exp_passes, vecs[i].exp_lat);
    end

    // Randomized traffic in a small window so loads revisit stored rows.
    strides[0] = 14'd0;  strides[1] = 14'd1;  strides[2] = 14'd2;  strides[3] = 14'd8;
    strides[4] = 14'd16; strides[5] = 14'd32; strides[6] = 14'd33; strides[7] = 14'd3;
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 127));
      s  = ($urandom_range(0, 3) == 0) ? SW'($urandom) : strides[$urandom_range(0, 7)];
      d  = rand_tile();
      conf = ref_conflict(a, s);
      do_txn($sformatf("rnd%0d", i), we, a, s, d, conf ? SZ : 1, conf ? LAT_SLOW : LAT_FAST);
    end

    // Back-pressure: hold the response while a second request waits.
    exp_a = ref_apply(1'b0, 15'h0000, 14'd1, '0);
    req_we = 1'b0; req_addr = 15'h0000; req_stride = 14'd1; req_data = '0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_int("bp first resp seen", int'(resp_valid), 1);
    check("bp first data", resp_data, exp_a);
    snap = resp_data;
    exp_b = ref_apply(1'b0, 15'h0005, 14'd16, '0);
    req_we = 1'b0; req_addr = 15'h0005; req_stride = 14'd16; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_int("bp resp_valid held", int'(resp_valid), 1);
      check("bp resp_data held", resp_data, snap);
      check_int("bp req_ready low", int'(req_ready), 0);
      check_int("bp no dc_we", int'(dc_we), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_int("bp resp dropped", int'(resp_valid), 0);
    check_int("bp ready for second", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_int("bp second accepted", int'(req_ready), 0);
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp second data", resp_data, exp_b);
    check_int("bp second passes", int'(resp_passes), SZ);
    $display("txn bp two loads held 10 cycles, second passes=%0d", resp_passes);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset in the middle of a slow-mode store.
    req_we = 1'b1; req_addr = 15'h4000; req_stride = 14'd0; req_data = make_tile(7); req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rst mid access dc_we", int'(dc_we), 1);
    resetn = 1'b0;
    #1;
    check_int("rst dc_we", int'(dc_we), 0);
    check_int("rst dc_addr", int'(dc_addr), 0);
    check_int("rst dc_stride_y", int'(dc_stride_y), 0);
    check("rst dc_dat_w", dc_dat_w, '0);
    check_int("rst req_ready", int'(req_ready), 1);
    check_int("rst resp_valid", int'(resp_valid), 0);
    check("rst resp_data", resp_data, '0);
    check_int("rst resp_passes", int'(resp_passes), 0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check_int("rst no response", seen, 0);
    $display("txn rst abandoned slow store at 4000");
    do_txn("post_rst_st", 1'b1, 15'h0100, 14'd1, make_tile(8), 1, LAT_FAST);
    do_txn("post_rst_ld", 1'b0, 15'h0100, 14'd1, '0, 1, LAT_FAST);

    rd = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_tile_port.md
Name: dcache_tile_port

Overview:
- Initiator side of the high-priority banked dcache: the unit that drives the dcache's addr/stride/dat_w/we inputs and captures its dat_r output.
- Accepts one SZ-row tile load or store per request from the core through a valid/ready handshake.
- Checks the SZ row addresses for bank conflicts. If there are none, it issues one strided dcache access. If there is a conflict, it serialises the tile into SZ single-row accesses.
- Returns a response per request in order, with read data and the pass count.

Parameters:
SZ, 4, rows per tile; also lanes per row
LOGCNT, 5, log2 of bank count; bank of an address = addr[LOGCNT-1:0]
BITS, 18, bits per element
ACC_CYC, 5, cycles the dcache inputs are held stable per access; must be >= 5

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_we  in  1  1=store tile, 0=load tile
req_addr  in  10+LOGCNT  row-0 address
req_stride  in  10+LOGCNT-1  row-to-row address stride
req_data  in  BITS*SZ*SZ  store data; row y at bits [BITS*SZ*y +: BITS*SZ]
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid&&resp_ready
resp_data  out  BITS*SZ*SZ  load data, same row packing; all-zero for stores
resp_passes  out  3  dcache accesses used: 1 or SZ
dc_addr  out  10+LOGCNT  to dcache addr
dc_stride_x  out  10+LOGCNT-1  to dcache stride_x; constant 0
dc_stride_y  out  10+LOGCNT-1  to dcache stride_y
dc_dat_w  out  BITS*SZ*SZ  to dcache dat_w
dc_we  out  1  to dcache we
dc_dat_r  in  BITS*SZ*SZ  from dcache dat_r

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_passes=0.
  - dc_addr=0; dc_stride_y=0; dc_dat_w=0; dc_we=0.
  - Reset mid-access abandons the request and produces no response. A partial store may already be written; that is acceptable.
- Row addresses: a_y = (req_addr + req_stride*y) mod 2^(10+LOGCNT). Wrap-around is silent.
- Conflict: true if any pair y!=z has a_y[LOGCNT-1:0]==a_z[LOGCNT-1:0]. Computed from latched request fields.
- IDLE:
  - req_ready=1.
  - On handshake, latch we/addr/stride/data, clear the capture register, go to CHECK.
- CHECK (1 cycle):
  - req_ready=0.
  - Register the conflict flag and set the row counter r=0.
  - Go to ACCESS.
- ACCESS, fast mode (no conflict):
  - dc_addr=req_addr; dc_stride_y=req_stride; dc_dat_w=req_data; dc_we=req_we.
  - All held constant for exactly ACC_CYC cycles.
- ACCESS, slow mode (conflict), one access per row r:
  - dc_addr=a_r; dc_stride_y=0.
  - dc_dat_w row 0 = req_data row r, all other rows 0; dc_we=req_we.
  - Held ACC_CYC cycles.
- Capture at the last ACCESS cycle:
  - Load, fast mode: capture register <= dc_dat_r (all rows).
  - Load, slow mode: capture row r <= dc_dat_r row 0.
  - Stores capture nothing.
- After each access: dc_we=0 for exactly 1 gap cycle. Then:
  - Slow mode with r<SZ-1: r++, ACCESS.
  - Otherwise: go to RESP.
- RESP:
  - resp_valid=1; resp_data=capture register (0 for store); resp_passes=1 (fast) or SZ (slow).
  - Outputs stay stable until resp_ready. On the handshake, resp_valid=0 and return to IDLE.
  - No new request is accepted until the response is consumed.
- Latency, handshake cycle 0 to first resp_valid cycle:
  - Fast mode: 2+ACC_CYC+1.
  - Slow mode: 2+SZ*(ACC_CYC+1).
- dc_we is asserted only in ACCESS cycles and never during a gap cycle.
- Only one request is outstanding at a time; no overlap of dcache accesses.

Test Plan:
- Store req_addr=0x0000, stride=1, rows=0x111..,0x222..,0x333..,0x444.. (banks 0,1,2,3). Then load the same. Expect resp_passes=1, load resp_data equal to the stored data, and store-response latency 8 cycles (ACC_CYC=5).
- Store then load at addr=0x0000, stride=32 (all rows bank 0). Expect resp_passes=4, data round-trips, latency 26 cycles, dc_stride_y=0 during every access.
- Addr=0x0005, stride=16 (banks 5,21,5,21) -> conflict, 4 passes. Rows read back at 0x0005/0x0015/0x0025/0x0035 individually, stride 0, each returning the expected row.
- Addr=0x7FFF, stride=1 -> a=0x7FFF,0x0000,0x0001,0x0002 (banks 31,0,1,2). Expect no conflict, 1 pass, and the write at 0x0000 lands in row 1 of a subsequent load from 0x7FFF.
- Hold resp_ready=0 for 10 cycles with req_valid=1 and a second request pending. Expect resp_valid and resp_data stable, req_ready=0, no dc_we pulse. Release -> second request accepted next cycle.
- Assert resetn low mid-ACCESS of a slow-mode store. Expect all outputs at reset values immediately, req_ready=1, no response, and the next request completes normally.
